// File: rtl/dmem_if.sv
// Core and host request/response bundle for the shared data memory.
// The master side issues requests; the arbiter sits on the slave side.
interface dmem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_lock;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  logic              busy;

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output h_req, h_we, h_addr, h_wdata, h_lock,
    input  c_gnt, c_rvalid, c_rdata,
    input  h_gnt, h_rvalid, h_rdata, busy
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  h_req, h_we, h_addr, h_wdata, h_lock,
    output c_gnt, c_rvalid, c_rdata,
    output h_gnt, h_rvalid, h_rdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data memory shared between the core and a host port, one access per 3 cycles.
// state  | meaning
// ARB    | pick a winner from c_req/h_req, latch its request
// ACCESS | winner's gnt high; write commits or read data loads at closing edge
// RESP   | winner's rvalid high for reads; requests ignored
module dmem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);
  typedef enum logic [1:0] {ARB, ACCESS, RESP} state_t;

  localparam logic CORE = 1'b0;
  localparam logic HOST = 1'b1;

  state_t            state, state_nxt;
  logic              prio;
  logic              lock_active;
  logic              win;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] h_rdata_q;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic any_req;
  logic lock_hold;
  logic eff_prio;
  logic host_win;

  // A lapsing lock hands priority back to the core in the same arbitration.
  always_comb begin
    any_req   = bus.c_req | bus.h_req;
    lock_hold = lock_active & bus.h_req & bus.h_lock;
    eff_prio  = (lock_active & ~lock_hold) ? CORE : prio;
    host_win  = bus.h_req & (~bus.c_req | lock_hold | (eff_prio == HOST));
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio        <= CORE;
      lock_active <= 1'b0;
      win         <= CORE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      c_rdata_q   <= '0;
      h_rdata_q   <= '0;
    end else begin
      case (state)
        ARB: begin
          if (any_req) begin
            win         <= host_win;
            we_q        <= host_win ? bus.h_we    : bus.c_we;
            addr_q      <= host_win ? bus.h_addr  : bus.c_addr;
            wdata_q     <= host_win ? bus.h_wdata : bus.c_wdata;
            prio        <= host_win ? CORE : HOST;
            lock_active <= host_win & bus.h_lock;
          end else if (lock_active) begin
            lock_active <= 1'b0;
            prio        <= CORE;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (win == HOST) h_rdata_q <= mem[addr_q];
            else             c_rdata_q <= mem[addr_q];
          end
        end
        default: ;
      endcase
    end
  end

  // Memory is never cleared; a reset at the closing ACCESS edge drops the write.
  always_ff @(posedge clk) begin
    if (reset && (state == ACCESS) && we_q) mem[addr_q] <= wdata_q;
  end

  assign bus.c_gnt    = (state == ACCESS) && (win == CORE);
  assign bus.h_gnt    = (state == ACCESS) && (win == HOST);
  assign bus.c_rvalid = (state == RESP) && !we_q && (win == CORE);
  assign bus.h_rvalid = (state == RESP) && !we_q && (win == HOST);
  assign bus.c_rdata  = c_rdata_q;
  assign bus.h_rdata  = h_rdata_q;
  assign bus.busy     = (state != ARB);
endmodule
